servo_sweep_ctrl: RTL

- Sequences the servo PWM output from the MCU's capacitive-touch GPIO.
- Synchronizes and debounces the touch line, then toggles the servo target between 0° and 180°.
- Slews the angle by a fixed step once per 20 ms PWM frame and drives the pulse-width generator, updating width only at frame boundaries so no frame is glitched.
- Sits between the MCU GPIO pin and the servo `pwm` pad in the FPGA top level, clocked from the 24 MHz internal oscillator.

---
 rtl/servo_pkg.sv | 29 ++
 rtl/servo_pwm_frame.sv | 66 ++++++
 rtl/servo_sweep_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared types and default timing for the touch-driven servo sweep controller.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    SWEEP_UP   = 2'd1,
    IDLE_HIGH  = 2'd2,
    SWEEP_DOWN = 2'd3
  } state_t;

  localparam int ANGLE_MAX = 180;

  // 24 MHz oscillator defaults: 20 ms frame, 1 ms..~2 ms pulse, 10 ms debounce.
  localparam int DEF_FRAME_CYCLES    = 480000;
  localparam int DEF_MIN_PULSE       = 24000;
  localparam int DEF_PULSE_PER_DEG   = 133;
  localparam int DEF_DEG_STEP        = 1;
  localparam int DEF_DEBOUNCE_CYCLES = 240000;

  // High time for a given angle; product formed at 32 bits, result kept at 16.
  function automatic logic [15:0] pulse_width(input logic [7:0]  ang,
                                               input logic [15:0] min_pulse,
                                               input logic [15:0] per_deg);
    logic [31:0] prod;
    prod = 32'(ang) * 32'(per_deg);
    return min_pulse + prod[15:0];
  endfunction

endpackage

// File: rtl/servo_pwm_frame.sv
// Frame counter and pulse-width comparator. The width only changes on the
// load strobe, which the controller drives with frame_tick, so a new width
// always starts cleanly at fc = 0.
module servo_pwm_frame
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int MIN_PULSE    = DEF_MIN_PULSE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] pw_next,
  output logic        pwm,
  output logic        frame_tick
);

  // At least 17 bits so the 16-bit width can always be zero-extended.
  localparam int FC_W = ($clog2(FRAME_CYCLES) > 16) ? $clog2(FRAME_CYCLES) : 17;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_PRE  = FC_W'(FRAME_CYCLES - 2);

  logic [FC_W-1:0] fc;
  logic [15:0]     pw;

  // Free-running frame position, wrapping at the end of each frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc <= '0;
    end else if (fc == FC_LAST) begin
      fc <= '0;
    end else begin
      fc <= fc + FC_W'(1);
    end
  end

  // Tick is registered one cycle early so it is high exactly while fc is last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (fc == FC_PRE);
    end
  end

  // Width register, reloaded only at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pw <= 16'(MIN_PULSE);
    end else if (load) begin
      pw <= pw_next;
    end else begin
      pw <= pw;
    end
  end

  // Registered compare: high for exactly pw cycles per frame, lagging fc by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (fc < {{(FC_W-16){1'b0}}, pw});
    end
  end

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Touch-toggled servo sweep: synchronizes and debounces the touch line,
// runs the sweep FSM, slews the angle once per frame and feeds the PWM frame.
module servo_sweep_ctrl
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES    = DEF_FRAME_CYCLES,
  parameter int MIN_PULSE       = DEF_MIN_PULSE,
  parameter int PULSE_PER_DEG   = DEF_PULSE_PER_DEG,
  parameter int DEG_STEP        = DEF_DEG_STEP,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic       touch,
  input  logic       hold,
  output logic       pwm,
  output logic [7:0] angle,
  output logic       moving,
  output logic       frame_tick
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            accepted;
  logic            press;
  logic [DB_W-1:0] deb_cnt;
  state_t          state;
  state_t          state_pt;
  state_t          next_state;
  logic [7:0]      next_angle;
  logic [8:0]      angle_up;
  logic [15:0]     pw_next;

  // Two-flop synchronizer for the asynchronous touch pin.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= touch;
      sync2 <= sync1;
    end
  end

  // Debounce: count cycles the synchronized level differs from the accepted
  // one; any return to the accepted level restarts the count. Only a rising
  // acceptance produces a press.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      deb_cnt  <= '0;
      accepted <= 1'b0;
      press    <= 1'b0;
    end else if (sync2 == accepted) begin
      deb_cnt  <= '0;
      accepted <= accepted;
      press    <= 1'b0;
    end else if (deb_cnt == DB_LAST) begin
      deb_cnt  <= '0;
      accepted <= sync2;
      press    <= sync2;
    end else begin
      deb_cnt  <= deb_cnt + DB_W'(1);
      accepted <= accepted;
      press    <= 1'b0;
    end
  end

  assign angle_up = {1'b0, angle} + 9'(DEG_STEP);

  // Press transition first, then the frame step in the resulting direction.
  always_comb begin
    state_pt   = state;
    next_state = state;
    next_angle = angle;
    if (press) begin
      case (state)
        IDLE_LOW:   state_pt = SWEEP_UP;
        SWEEP_UP:   state_pt = SWEEP_DOWN;
        IDLE_HIGH:  state_pt = SWEEP_DOWN;
        SWEEP_DOWN: state_pt = SWEEP_UP;
        default:    state_pt = IDLE_LOW;
      endcase
    end else begin
      state_pt = state;
    end
    next_state = state_pt;
    if (frame_tick && !hold) begin
      case (state_pt)
        SWEEP_UP: begin
          if (angle_up >= 9'(ANGLE_MAX)) begin
            next_angle = 8'(ANGLE_MAX);
            next_state = IDLE_HIGH;
          end else begin
            next_angle = angle_up[7:0];
            next_state = SWEEP_UP;
          end
        end
        SWEEP_DOWN: begin
          if (angle <= 8'(DEG_STEP)) begin
            next_angle = 8'd0;
            next_state = IDLE_LOW;
          end else begin
            next_angle = angle - 8'(DEG_STEP);
            next_state = SWEEP_DOWN;
          end
        end
        default: begin
          next_angle = angle;
          next_state = state_pt;
        end
      endcase
    end else begin
      next_angle = angle;
      next_state = state_pt;
    end
  end

  assign pw_next = pulse_width(next_angle, 16'(MIN_PULSE), 16'(PULSE_PER_DEG));

  // Sweep state, commanded angle and the moving flag.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state  <= IDLE_LOW;
      angle  <= 8'd0;
      moving <= 1'b0;
    end else begin
      state  <= next_state;
      angle  <= next_angle;
      moving <= (next_state == SWEEP_UP) || (next_state == SWEEP_DOWN);
    end
  end

  servo_pwm_frame #(
    .FRAME_CYCLES(FRAME_CYCLES),
    .MIN_PULSE   (MIN_PULSE)
  ) u_frame (
    .clk       (int_osc),
    .rst       (reset),
    .load      (frame_tick),
    .pw_next   (pw_next),
    .pwm       (pwm),
    .frame_tick(frame_tick)
  );

endmodule
